// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: default widths, the
// reset vector, the run/halt state encoding and the next-PC source select.
package pc_pkg;

  // Default PC / instruction-address width.
  localparam int PC_W = 16;

  // Default width of the signed B-instruction offset, in instruction words.
  localparam int IMM_W = 9;

  // Default PC value loaded on reset.
  localparam logic [15:0] RESET_PC = 16'h0000;

  // Width of the retired-instruction counter.
  localparam int RET_W = 16;

  // Saturation value of the retired-instruction counter.
  localparam logic [RET_W-1:0] RET_MAX = 16'hFFFF;

  // Fetch state: RUN advances the PC; HALTED freezes everything until reset.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

  // Which source feeds the PC register on the next rising edge.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,  // stalled, halted, or executing HLT
    SEL_SEQ  = 2'd1,  // sequential: pc + 2
    SEL_B    = 2'd2,  // PC-relative: pc + 2 + (sext(imm) << 1)
    SEL_BR   = 2'd3   // register target with bit 0 cleared
  } pc_sel_e;

endpackage

// File: rtl/pc_adder.sv
// Plain modulo-2^W adder. The PC stage uses one instance for the sequential
// increment and a second, chained after it, for the PC-relative target.
module pc_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // Carry out is dropped on purpose: PC arithmetic wraps silently.
  always_comb begin
    sum = a + b;
  end

endmodule

// File: rtl/pc_control.sv
// Program-counter stage. Holds the architectural PC, picks the next PC from
// the sequential increment, a taken B target or a taken BR target, and
// tracks halt state, a one-cycle redirect pulse and a saturating count of
// retired instructions. Every output except pc_plus2 comes from a flop.
module pc_control #(
  parameter int              PC_W     = pc_pkg::PC_W,
  parameter int              IMM_W    = pc_pkg::IMM_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(pc_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             is_b,
  input  logic             is_br,
  input  logic             branch_taken,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  reg_target,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             redirect,
  output logic             halted,
  output logic [15:0]      retired
);

  import pc_pkg::*;

  // Sequential step: one 16-bit instruction word is two bytes.
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

  // Architectural state.
  logic [PC_W-1:0]  pc_q, pc_d;
  pc_state_e        state_q, state_d;
  logic             redirect_q, redirect_d;
  logic [RET_W-1:0] retired_q, retired_d;

  // Datapath intermediates.
  logic [PC_W-1:0] imm_sext_s;
  logic [PC_W-1:0] offset_s;
  logic [PC_W-1:0] pc_plus2_s;
  logic [PC_W-1:0] b_target_s;
  logic [PC_W-1:0] br_target_s;

  // Control intermediates.
  logic    advance_s;
  logic    b_take_s;
  logic    br_take_s;
  pc_sel_e sel_s;

  // Bits that are architecturally ignored, gathered in one place.
  logic unused_s;

  // Sign-extend the word offset to PC width, then scale words to bytes;
  // extension happens first so negative offsets keep their sign.
  always_comb begin
    imm_sext_s = {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
    offset_s   = {imm_sext_s[PC_W-2:0], 1'b0};
  end

  // Register-target jumps always land on an even address.
  always_comb begin
    br_target_s = {reg_target[PC_W-1:1], 1'b0};
    unused_s    = reg_target[0] ^ imm_sext_s[PC_W-1];
  end

  // pc + 2 feeds both the sequential path and the PCS writeback port.
  pc_adder #(
    .W (PC_W)
  ) u_inc_adder (
    .a   (pc_q),
    .b   (PC_STEP),
    .sum (pc_plus2_s)
  );

  // B target is relative to the following instruction, not to the B itself.
  pc_adder #(
    .W (PC_W)
  ) u_branch_adder (
    .a   (pc_plus2_s),
    .b   (offset_s),
    .sum (b_target_s)
  );

  // An advance is any RUN cycle without a stall; branch_taken only counts
  // when the instruction is actually a branch.
  always_comb begin
    advance_s = (state_q == RUN) && !stall;
    b_take_s  = is_b && branch_taken;
    br_take_s = is_br && branch_taken;
  end

  // Next-PC source priority: HLT over B over BR over sequential.
  always_comb begin
    sel_s = SEL_HOLD;
    if (!advance_s) begin
      sel_s = SEL_HOLD;
    end else if (halt_req) begin
      sel_s = SEL_HOLD;
    end else if (b_take_s) begin
      sel_s = SEL_B;
    end else if (br_take_s) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux and redirect pulse, driven by the selected source.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    case (sel_s)
      SEL_HOLD: begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
      end
      SEL_SEQ: begin
        pc_d       = pc_plus2_s;
        redirect_d = 1'b0;
      end
      SEL_B: begin
        pc_d       = b_target_s;
        redirect_d = 1'b1;
      end
      SEL_BR: begin
        pc_d       = br_target_s;
        redirect_d = 1'b1;
      end
      default: begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
      end
    endcase
  end

  // Run/halt FSM next state: only an HLT advance leaves RUN, only reset
  // leaves HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (advance_s && halt_req) begin
          state_d = HALTED;
        end else begin
          state_d = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Retired counter counts every advance, HLT included, and sticks at max.
  always_comb begin
    retired_d = retired_q;
    if (!advance_s) begin
      retired_d = retired_q;
    end else if (retired_q == RET_MAX) begin
      retired_d = RET_MAX;
    end else begin
      retired_d = retired_q + 16'd1;
    end
  end

  // State registers; reset wins over stall, halt and the HALTED state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      redirect_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
      retired_q  <= retired_d;
    end
  end

  // Output wiring.
  always_comb begin
    pc       = pc_q;
    pc_plus2 = pc_plus2_s;
    redirect = redirect_q;
    halted   = (state_q == HALTED);
    retired  = retired_q;
  end

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: every driven cycle pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares
// after each rising edge. A few directed constant checks follow the plan.
module tb_pc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        is_b = 1'b0;
  logic        is_br = 1'b0;
  logic        branch_taken = 1'b0;
  logic [8:0]  imm = 9'd0;
  logic [15:0] reg_target = 16'd0;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        redirect;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  pc_control dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .halt_req     (halt_req),
    .is_b         (is_b),
    .is_br        (is_br),
    .branch_taken (branch_taken),
    .imm          (imm),
    .reg_target   (reg_target),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .redirect     (redirect),
    .halted       (halted),
    .retired      (retired)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pc2;
    logic        redirect;
    logic        halted;
    logic [15:0] retired;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   shown = 0;

  // Reference model state.
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ret = 16'h0000;
  logic        m_halted = 1'b0;
  logic        m_redir = 1'b0;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      if (shown < 40) begin
        shown++;
        $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
      end
    end
  endtask

  // Architectural rules applied once per rising edge.
  task automatic model_step(input bit r, input bit s, input bit h, input bit b,
                            input bit br, input bit t, input logic [8:0] im,
                            input logic [15:0] tg);
    int off;
    off = int'($signed(im));
    if (r) begin
      m_pc = 16'h0000; m_halted = 1'b0; m_redir = 1'b0; m_ret = 16'h0000;
    end else if (m_halted || s) begin
      m_redir = 1'b0;
    end else begin
      m_ret = (m_ret == 16'hFFFF) ? 16'hFFFF : m_ret + 16'd1;
      if (h) begin
        m_halted = 1'b1; m_redir = 1'b0;
      end else if (b && t) begin
        m_pc = 16'(int'(m_pc) + 2 + 2 * off); m_redir = 1'b1;
      end else if (br && t) begin
        m_pc = tg & 16'hFFFE; m_redir = 1'b1;
      end else begin
        m_pc = 16'(int'(m_pc) + 2); m_redir = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs and push the expected response.
  task automatic cyc(input bit r, input bit s, input bit h, input bit b,
                     input bit br, input bit t, input logic [8:0] im,
                     input logic [15:0] tg);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; halt_req = h; is_b = b; is_br = br;
    branch_taken = t; imm = im; reg_target = tg;
    model_step(r, s, h, b, br, t, im, tg);
    e.pc = m_pc; e.pc2 = m_pc + 16'd2; e.redirect = m_redir;
    e.halted = m_halted; e.retired = m_ret;
    sbq.push_back(e);
  endtask

  task automatic adv();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
  endtask

  task automatic setpc(input logic [15:0] v);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, v);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected record per edge, compared just after the edge.
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      report("sb_pc", 32'(pc), 32'(me.pc));
      report("sb_pc_plus2", 32'(pc_plus2), 32'(me.pc2));
      report("sb_redirect", 32'(redirect), 32'(me.redirect));
      report("sb_halted", 32'(halted), 32'(me.halted));
      report("sb_retired", 32'(retired), 32'(me.retired));
    end
  end

  logic [15:0] ret_snap;

  initial begin
    // Reset and three sequential advances.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
    after_edge();
    report("rst_pc", 32'(pc), 32'h0000);
    report("rst_halted", 32'(halted), 32'h0);
    report("rst_retired", 32'(retired), 32'h0);
    report("rst_redirect", 32'(redirect), 32'h0);
    adv(); after_edge();
    report("seq_pc1", 32'(pc), 32'h0002);
    adv(); adv(); after_edge();
    report("seq_pc3", 32'(pc), 32'h0006);
    report("seq_retired3", 32'(retired), 32'h0003);
    report("seq_redirect", 32'(redirect), 32'h0);

    // Backward B taken, pulse lasts one cycle; untaken B is sequential.
    setpc(16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1FC, 16'd0); after_edge();
    report("b_neg_pc", 32'(pc), 32'h000A);
    report("b_neg_redirect", 32'(redirect), 32'h1);
    adv(); after_edge();
    report("b_pulse_end", 32'(redirect), 32'h0);
    setpc(16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FC, 16'd0); after_edge();
    report("b_untaken_pc", 32'(pc), 32'h0012);

    // BR clears bit 0; B wins when both are set.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 16'h1235); after_edge();
    report("br_pc", 32'(pc), 32'h1234);
    setpc(16'h0020);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h001, 16'h5555); after_edge();
    report("b_over_br_pc", 32'(pc), 32'h0024);

    // Stall holds a pending branch for three cycles.
    setpc(16'h0040);
    after_edge();
    ret_snap = m_ret;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'h004, 16'd0); after_edge();
      report("stall_pc", 32'(pc), 32'h0040);
      report("stall_redirect", 32'(redirect), 32'h0);
      report("stall_retired", 32'(retired), 32'(ret_snap));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h004, 16'd0); after_edge();
    report("stall_release_pc", 32'(pc), 32'h004A);
    report("stall_release_redirect", 32'(redirect), 32'h1);

    // HLT beats a taken branch and is sticky until reset.
    setpc(16'h0050);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h008, 16'd0); after_edge();
    report("halt_pc", 32'(pc), 32'h0050);
    report("halt_flag", 32'(halted), 32'h1);
    report("halt_redirect", 32'(redirect), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
          1'b1, 1'b1, 9'($urandom_range(0, 511)), 16'($urandom));
    end
    after_edge();
    report("halt_sticky", 32'(halted), 32'h1);
    report("halt_sticky_pc", 32'(pc), 32'h0050);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0); after_edge();
    report("halt_rst_pc", 32'(pc), 32'h0000);
    report("halt_rst_flag", 32'(halted), 32'h0);

    // Wrap-around of the sequential increment.
    setpc(16'hFFFE);
    adv(); after_edge();
    report("wrap_pc", 32'(pc), 32'h0000);
    report("wrap_pc_plus2", 32'(pc_plus2), 32'h0002);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          9'($urandom_range(0, 511)), 16'($urandom));
    end

    // Retired counter saturation.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
    for (int i = 0; i < 65540; i++) begin
      adv();
    end
    after_edge();
    report("sat_retired", 32'(retired), 32'h0000FFFF);
    report("sat_pc", 32'(pc), 32'h0008);

    repeat (3) @(posedge clk);
    #2;
    report("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
